mips_multicycle_ctrl: RTL and testbench
=======================================

# mips_multicycle_ctrl

Multicycle MIPS control unit: the initiator that drives the 4-bit ALU operation code and the datapath control lines, one instruction at a time. It takes opcode/funct from the instruction register and the ALU zero flag back from the ALU. It sequences fetch, decode, execute, memory and write-back as a Moore FSM, and waits on a memory ready handshake. It sits between the instruction register and the datapath muxes, register file, PC, memory and ALU.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; stable from DECODE until instruction end
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, valid in BRANCH
- mem_ready  in  1  memory access completes this cycle
- alu_op  out  4  ALU code: add 0000, sub 0001, sll1 0100, srl1 1100, and 1000, or 1001, xor 1010, nor 1011, gt 1110, eq 1111
- alu_swap  out  1  swap ALU operands (slt as rt>rs)
- alu_src_a  out  1  0=PC, 1=A register
- alu_src_b  out  2  00=B, 01=const 4, 10=immediate, 11=sign-ext imm<<2
- zero_ext  out  1  immediate is zero-extended (andi/ori/xori)
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst, mem_to_reg  out  1 each  standard multicycle controls
- illegal  out  1  one-cycle pulse on undecodable instruction
- state  out  4  current state, debug

## Operation
- States: RESET(0), FETCH(1), DECODE(2), MEMADDR(3), MEMREAD(4), MEMWB(5), MEMWRITE(6), EXEC_R(7), RWB(8), EXEC_I(9), IWB(10), BRANCH(11), JUMP(12), TRAP(13). Codes 14–15 are unused; if reached, go to FETCH.
- Outputs are a pure function of state, plus mem_ready, zero and opcode as noted. Any output not listed for a state is 0.
- RESET: all outputs 0 → FETCH.
- FETCH: mem_read=1, alu_src_b=01, alu_op=add. When mem_ready=1, also ir_write=1 and pc_write=1 → DECODE; otherwise stay.
- DECODE: alu_src_b=11, alu_op=add. Next state:
  - lw 100011 / sw 101011 → MEMADDR
  - R-type 000000 with legal funct → EXEC_R
  - addi 001000, andi 001100, ori 001101, xori 001110 → EXEC_I
  - beq 000100 / bne 000101 → BRANCH
  - j 000010 → JUMP
  - anything else → TRAP
- MEMADDR: alu_src_a=1, alu_src_b=10, add → MEMREAD (lw) or MEMWRITE (sw).
- MEMREAD: mem_read=1, i_or_d=1; wait for mem_ready → MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1 → FETCH.
- MEMWRITE: mem_write=1, i_or_d=1; wait for mem_ready → FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op from funct → RWB. Funct map:
  - add 100000, sub 100010, and 100100, or 100101, xor 100110, nor 100111
  - sll 000000 → sll1; srl 000010 → srl1; shamt is ignored (shift by one)
  - slt 101010 → gt with alu_swap=1
- RWB: reg_write=1, reg_dst=1 → FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op add/and/or/xor per opcode; zero_ext=1 except for addi → IWB.
- IWB: reg_write=1 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_source=01, pc_write = zero (beq) or ~zero (bne) → FETCH.
- JUMP: pc_source=10, pc_write=1 → FETCH.
- TRAP: illegal=1 → FETCH. The PC has already advanced by 4.

## Timing
- rst_n low asynchronously forces state=RESET and all outputs to 0. FETCH is entered on the first rising edge after rst_n rises.
- A reset asserted mid-instruction abandons it. No write strobe may remain high once rst_n is low.
- Zero-wait-state latency in cycles: R-type 4, addi/andi/ori/xori 4, lw 5, sw 4, beq/bne 3, j 3, illegal 3.
- Each cycle that mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle. The strobes are held and outputs stay constant.
- mem_ready is ignored in every state other than FETCH, MEMREAD and MEMWRITE.
- pc_write, ir_write, reg_write and mem_write are each high for exactly one cycle per access, except mem_write, which is held while waiting.

## Test plan
- Reset release, then add (opcode 0, funct 100000) with mem_ready=1: states 0→1→2→7→8→1; alu_op 0000 in EXEC_R; reg_write=1 and reg_dst=1 for exactly one cycle.
- lw with mem_ready low for 2 cycles in MEMREAD: MEMREAD lasts 3 cycles with mem_read=i_or_d=1 throughout; total 7 cycles; MEMWB asserts mem_to_reg=1.
- beq with zero=1, then zero=0: pc_write=1 then 0 in BRANCH, pc_source=01, alu_op=0001. bne with zero=0 gives pc_write=1.
- slt (funct 101010): alu_op=1110 with alu_swap=1. ori (001101): alu_op=1001 with zero_ext=1. nor: alu_op=1011.
- Opcode 111111, and R-type funct 001000: illegal pulses for one cycle in TRAP, then FETCH.
- rst_n dropped during MEMWRITE with mem_ready low: mem_write falls immediately, state=0; after release the unit restarts in FETCH.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute,
// memory and write-back, and drives the ALU code and datapath control lines.
`timescale 1ns/1ps
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] alu_op,
    output logic       alu_swap,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       zero_ext,
    output logic [1:0] pc_source,
    output logic       pc_write,
    output logic       ir_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADDR  = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXEC_R   = 4'd7,
        S_RWB      = 4'd8,
        S_EXEC_I   = 4'd9,
        S_IWB      = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL1 = 4'b0100;
    localparam logic [3:0] ALU_SRL1 = 4'b1100;
    localparam logic [3:0] ALU_AND  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1010;
    localparam logic [3:0] ALU_NOR  = 4'b1011;
    localparam logic [3:0] ALU_GT   = 4'b1110;

    // R-type funct decode packed as {legal, swap, alu_op}
    function automatic logic [5:0] r_decode(input logic [5:0] fn);
        case (fn)
            6'b100000: r_decode = {1'b1, 1'b0, ALU_ADD};
            6'b100010: r_decode = {1'b1, 1'b0, ALU_SUB};
            6'b100100: r_decode = {1'b1, 1'b0, ALU_AND};
            6'b100101: r_decode = {1'b1, 1'b0, ALU_OR};
            6'b100110: r_decode = {1'b1, 1'b0, ALU_XOR};
            6'b100111: r_decode = {1'b1, 1'b0, ALU_NOR};
            6'b000000: r_decode = {1'b1, 1'b0, ALU_SLL1};
            6'b000010: r_decode = {1'b1, 1'b0, ALU_SRL1};
            6'b101010: r_decode = {1'b1, 1'b1, ALU_GT};
            default:   r_decode = {1'b0, 1'b0, ALU_ADD};
        endcase
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic [5:0] r_dec_s;

    assign r_dec_s = r_decode(funct);
    assign state   = state_r;

    // State register; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_RESET;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_next_s = S_FETCH;
        case (state_r)
            S_RESET:  state_next_s = S_FETCH;
            S_FETCH: begin
                if (mem_ready) state_next_s = S_DECODE;
                else           state_next_s = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next_s = S_MEMADDR;
                    OP_RTYPE: begin
                        if (r_dec_s[5]) state_next_s = S_EXEC_R;
                        else            state_next_s = S_TRAP;
                    end
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_next_s = S_EXEC_I;
                    OP_BEQ, OP_BNE: state_next_s = S_BRANCH;
                    OP_J:           state_next_s = S_JUMP;
                    default:        state_next_s = S_TRAP;
                endcase
            end
            S_MEMADDR: begin
                if (opcode == OP_LW) state_next_s = S_MEMREAD;
                else                 state_next_s = S_MEMWRITE;
            end
            S_MEMREAD: begin
                if (mem_ready) state_next_s = S_MEMWB;
                else           state_next_s = S_MEMREAD;
            end
            S_MEMWRITE: begin
                if (mem_ready) state_next_s = S_FETCH;
                else           state_next_s = S_MEMWRITE;
            end
            S_EXEC_R: state_next_s = S_RWB;
            S_EXEC_I: state_next_s = S_IWB;
            S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP, S_TRAP: state_next_s = S_FETCH;
            default:  state_next_s = S_FETCH;
        endcase
    end

    // Moore outputs from the current state, qualified by mem_ready, zero and opcode
    always_comb begin
        alu_op     = ALU_ADD;
        alu_swap   = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        zero_ext   = 1'b0;
        pc_source  = 2'b00;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal    = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:  alu_src_b = 2'b11;
            S_MEMADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = r_dec_s[3:0];
                alu_swap  = r_dec_s[4];
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (opcode)
                    OP_ANDI: begin alu_op = ALU_AND; zero_ext = 1'b1; end
                    OP_ORI:  begin alu_op = ALU_OR;  zero_ext = 1'b1; end
                    OP_XORI: begin alu_op = ALU_XOR; zero_ext = 1'b1; end
                    default: begin alu_op = ALU_ADD; zero_ext = 1'b0; end
                endcase
            end
            S_IWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = 2'b01;
                if (opcode == OP_BNE) pc_write = ~zero;
                else                  pc_write = zero;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
            end
            S_TRAP:  illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl: a per-instruction table model builds the
// expected cycle-by-cycle state/output trace, compared against the DUT at each negedge.
`timescale 1ns/1ps
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [3:0] alu_op, state;
    logic       alu_swap, alu_src_a, zero_ext;
    logic [1:0] alu_src_b, pc_source;
    logic       pc_write, ir_write, i_or_d, mem_read, mem_write;
    logic       reg_write, reg_dst, mem_to_reg, illegal;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .alu_op(alu_op), .alu_swap(alu_swap),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .zero_ext(zero_ext),
        .pc_source(pc_source), .pc_write(pc_write), .ir_write(ir_write),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    logic [23:0] obs_s;
    assign obs_s = {state, alu_op, alu_swap, alu_src_a, alu_src_b, zero_ext, pc_source,
                    pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, reg_dst,
                    mem_to_reg, illegal};

    localparam logic [8:0] PCW = 9'h100, IRW = 9'h080, IORD = 9'h040, MRD = 9'h020;
    localparam logic [8:0] MWR = 9'h010, RW = 9'h008, RDST = 9'h004, M2R = 9'h002;
    localparam logic [8:0] ILL = 9'h001, NONE = 9'h000;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101, JMP = 6'b000010, RT = 6'b000000;

    typedef struct {
        logic [23:0] exp;
        logic        rdy;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Spec tables: R-type funct -> {swap, alu_op}; I-type opcode -> {zero_ext, alu_op}
    logic [4:0] r_tab [logic [5:0]];
    logic [4:0] i_tab [logic [5:0]];
    logic [5:0] r_list [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                               6'b100111, 6'b000000, 6'b000010, 6'b101010};
    logic [5:0] i_list [4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001110};

    function automatic logic [23:0] mk(input logic [3:0] st, input logic [3:0] aop,
                                       input logic sw, input logic sa, input logic [1:0] sb,
                                       input logic zx, input logic [1:0] ps,
                                       input logic [8:0] strb);
        return {st, aop, sw, sa, sb, zx, ps, strb};
    endfunction

    function automatic void push(input logic [23:0] e, input logic r, input logic [5:0] o,
                                 input logic [5:0] f, input logic z);
        ent_t t;
        t.exp = e; t.rdy = r; t.op = o; t.fn = f; t.z = z;
        q.push_back(t);
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(1, 0));
    endfunction

    // Expected trace of one instruction: fw fetch stalls, mw memory stalls
    function automatic void add_instr(input logic [5:0] op, input logic [5:0] fn,
                                      input logic z, input int fw, input int mw);
        logic [4:0] e;
        for (int i = 0; i < fw; i++)
            push(mk(4'd1, 4'b0000, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, MRD), 1'b0,
                 6'($urandom), 6'($urandom), z);
        push(mk(4'd1, 4'b0000, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00, MRD | IRW | PCW), 1'b1,
             6'($urandom), 6'($urandom), z);
        push(mk(4'd2, 4'b0000, 1'b0, 1'b0, 2'b11, 1'b0, 2'b00, NONE), rbit(), op, fn, z);
        if (op == LW || op == SW) begin
            push(mk(4'd3, 4'b0000, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00, NONE), rbit(), op, fn, z);
            for (int i = 0; i <= mw; i++) begin
                if (op == LW)
                    push(mk(4'd4, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, MRD | IORD),
                         (i == mw), op, fn, z);
                else
                    push(mk(4'd6, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, MWR | IORD),
                         (i == mw), op, fn, z);
            end
            if (op == LW)
                push(mk(4'd5, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, RW | M2R), rbit(), op, fn, z);
        end else if (op == RT && r_tab.exists(fn)) begin
            e = r_tab[fn];
            push(mk(4'd7, e[3:0], e[4], 1'b1, 2'b00, 1'b0, 2'b00, NONE), rbit(), op, fn, z);
            push(mk(4'd8, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, RW | RDST), rbit(), op, fn, z);
        end else if (i_tab.exists(op)) begin
            e = i_tab[op];
            push(mk(4'd9, e[3:0], 1'b0, 1'b1, 2'b10, e[4], 2'b00, NONE), rbit(), op, fn, z);
            push(mk(4'd10, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, RW), rbit(), op, fn, z);
        end else if (op == BEQ || op == BNE) begin
            push(mk(4'd11, 4'b0001, 1'b0, 1'b1, 2'b00, 1'b0, 2'b01,
                    ((op == BEQ) == z) ? PCW : NONE), rbit(), op, fn, z);
        end else if (op == JMP) begin
            push(mk(4'd12, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10, PCW), rbit(), op, fn, z);
        end else begin
            push(mk(4'd13, 4'b0000, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, ILL), rbit(), op, fn, z);
        end
    endfunction

    // Drive one cycle of stimulus just after posedge and sample at the following negedge
    task automatic drive_entry(input ent_t e, output logic [23:0] obs);
        mem_ready = e.rdy;
        opcode    = e.op;
        funct     = e.fn;
        zero      = e.z;
        @(negedge clk);
        obs = obs_s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs_s !== 24'h0) begin
            n_err++;
            $display("FAIL reset_hold: got %h want %h", obs_s, 24'h0);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (obs_s !== 24'h0) begin
            n_err++;
            $display("FAIL reset_release: got %h want %h", obs_s, 24'h0);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (state !== 4'd1) begin
            n_err++;
            $display("FAIL reset_to_fetch: state got %0d want 1", state);
        end
    endtask

    task automatic test_add();
        logic [23:0] obs;
        q.delete();
        add_instr(RT, 6'b100000, 1'b0, 0, 0);
        foreach (q[i]) begin
            drive_entry(q[i], obs);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_err++;
                $display("FAIL add cycle %0d: got %h want %h", i, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_lw_wait();
        logic [23:0] obs;
        q.delete();
        add_instr(LW, 6'($urandom), 1'b0, 0, 2);
        add_instr(SW, 6'($urandom), 1'b1, 1, 1);
        foreach (q[i]) begin
            drive_entry(q[i], obs);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_err++;
                $display("FAIL lw_sw_wait cycle %0d: got %h want %h", i, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_branch();
        logic [23:0] obs;
        q.delete();
        add_instr(BEQ, 6'($urandom), 1'b1, 0, 0);
        add_instr(BEQ, 6'($urandom), 1'b0, 0, 0);
        add_instr(BNE, 6'($urandom), 1'b0, 0, 0);
        add_instr(BNE, 6'($urandom), 1'b1, 0, 0);
        add_instr(JMP, 6'($urandom), 1'b0, 0, 0);
        foreach (q[i]) begin
            drive_entry(q[i], obs);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_err++;
                $display("FAIL branch_jump cycle %0d: got %h want %h", i, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_alu_ops();
        logic [23:0] obs;
        q.delete();
        foreach (r_list[k]) add_instr(RT, r_list[k], rbit(), 0, 0);
        foreach (i_list[k]) add_instr(i_list[k], 6'($urandom), rbit(), 0, 0);
        foreach (q[i]) begin
            drive_entry(q[i], obs);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_err++;
                $display("FAIL alu_ops cycle %0d op %b fn %b: got %h want %h",
                         i, q[i].op, q[i].fn, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_illegal();
        logic [23:0] obs;
        q.delete();
        add_instr(6'b111111, 6'($urandom), 1'b0, 0, 0);
        add_instr(RT, 6'b001000, 1'b0, 0, 0);
        add_instr(6'b000001, 6'b100000, 1'b0, 1, 0);
        foreach (q[i]) begin
            drive_entry(q[i], obs);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_err++;
                $display("FAIL illegal cycle %0d: got %h want %h", i, obs, q[i].exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [23:0] obs;
        q.delete();
        add_instr(SW, 6'($urandom), 1'b0, 0, 5);
        for (int i = 0; i < 4; i++) begin
            drive_entry(q[i], obs);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_err++;
                $display("FAIL reset_mid_pre cycle %0d: got %h want %h", i, obs, q[i].exp);
            end
        end
        mem_ready = 1'b0;
        #2;
        n_cmp++;
        if (obs_s !== q[4].exp) begin
            n_err++;
            $display("FAIL reset_mid_memwrite: got %h want %h", obs_s, q[4].exp);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs_s !== 24'h0) begin
            n_err++;
            $display("FAIL reset_mid_async: got %h want %h", obs_s, 24'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (obs_s !== 24'h0) begin
            n_err++;
            $display("FAIL reset_mid_release: got %h want %h", obs_s, 24'h0);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (state !== 4'd1 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_restart: state %0d mem_read %b mem_write %b want 1/1/0",
                     state, mem_read, mem_write);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] obs;
        logic [5:0]  op, fn;
        q.delete();
        for (int n = 0; n < 200; n++) begin
            fn = 6'($urandom);
            case ($urandom_range(8, 0))
                0: op = LW;
                1: op = SW;
                2: begin op = RT; fn = r_list[$urandom_range(8, 0)]; end
                3: op = RT;
                4: op = i_list[$urandom_range(3, 0)];
                5: op = BEQ;
                6: op = BNE;
                7: op = JMP;
                default: op = 6'($urandom);
            endcase
            add_instr(op, fn, rbit(), $urandom_range(2, 0), $urandom_range(3, 0));
        end
        foreach (q[i]) begin
            drive_entry(q[i], obs);
            n_cmp++;
            if (obs !== q[i].exp) begin
                n_err++;
                $display("FAIL back_to_back cycle %0d op %b fn %b: got %h want %h",
                         i, q[i].op, q[i].fn, obs, q[i].exp);
            end
        end
    endtask

    initial begin
        r_tab[6'b100000] = {1'b0, 4'b0000};
        r_tab[6'b100010] = {1'b0, 4'b0001};
        r_tab[6'b100100] = {1'b0, 4'b1000};
        r_tab[6'b100101] = {1'b0, 4'b1001};
        r_tab[6'b100110] = {1'b0, 4'b1010};
        r_tab[6'b100111] = {1'b0, 4'b1011};
        r_tab[6'b000000] = {1'b0, 4'b0100};
        r_tab[6'b000010] = {1'b0, 4'b1100};
        r_tab[6'b101010] = {1'b1, 4'b1110};
        i_tab[6'b001000] = {1'b0, 4'b0000};
        i_tab[6'b001100] = {1'b1, 4'b1000};
        i_tab[6'b001101] = {1'b1, 4'b1001};
        i_tab[6'b001110] = {1'b1, 4'b1010};
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_alu_ops();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
